load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_WORDS, default 1024, SHALL give the data-memory depth in 32-bit words; power of two.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req_valid  input  1  CPU access request present.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal.
REQ-008 req_unsigned  input  1  zero-extend sub-word loads (lbu/lhu) when 1, sign-extend when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-013 resp_err  output  1  with resp_valid: misaligned, illegal size or out-of-range access.
REQ-014 mem_addr  output  32  word index into data memory, equal to req_addr >> 2.
REQ-015 mem_wdata  output  32  full word to write.
REQ-016 mem_write  output  1  memory write strobe.
REQ-017 mem_read  output  1  memory read strobe.
REQ-018 mem_rdata  input  32  memory read word, valid by the end of the cycle mem_read is high.

Function
REQ-019 The FSM SHALL have the states IDLE, RD, WR, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 The unit SHALL accept a request when req_valid && req_ready and register addr, size, unsigned, write and wdata.
REQ-021 The accepted request SHALL be an error when size is 11, a halfword has addr[0]=1, a word has addr[1:0]!=0, or addr >= 4*MEM_WORDS.
REQ-022 On an error the FSM SHALL go IDLE->RESP with resp_err=1, and mem_read and mem_write SHALL never assert.
REQ-023 Load: IDLE->RD->RESP; RD asserts mem_read for exactly one cycle and captures mem_rdata at the end of RD; resp_valid occurs 2 cycles after accept.
REQ-024 Word store: IDLE->WR->RESP; WR asserts mem_write for exactly one cycle with mem_wdata=req_wdata.
REQ-025 Byte/halfword store SHALL be read-modify-write, IDLE->RD->WR->RESP; it replaces only lane addr[1:0] (byte) or addr[1] (halfword) and preserves all other bits; resp_valid occurs 3 cycles after accept.
REQ-026 Load extraction SHALL select byte lane addr[1:0] or halfword lane addr[1] and extend it to 32 bits per req_unsigned; word loads pass through unchanged.
REQ-027 mem_read and mem_write SHALL never both be high; both SHALL be 0 outside RD/WR.
REQ-028 mem_addr and mem_wdata SHALL be stable throughout RD and WR; they are don't-care elsewhere.
REQ-029 RESP SHALL last one cycle and then return to IDLE; a new request is accepted no earlier than the cycle after RESP.
REQ-030 req_valid, and changes to the request fields, while req_ready=0 SHALL be ignored.

Reset
REQ-031 While rst_n=0, the FSM SHALL be IDLE and req_ready=1; resp_valid, resp_err, mem_read, mem_write, resp_rdata and the internal registers SHALL be 0.
REQ-032 Reset asserted during RD or WR SHALL drop the memory strobes immediately, without waiting for a clock, and SHALL abandon the request with no response.

Structure
REQ-033 A shared package SHALL hold the size codes (SZ_BYTE/SZ_HALF/SZ_WORD) and the FSM state encoding.
REQ-034 Lane extraction/extension and lane merge SHALL be a combinational sub-module, lsu_lane_align, reused by the load and store paths.

Verification
REQ-035 Bench: store word 0xDEADBEEF @0x10 then load word @0x10 -> mem_write once with mem_addr=4; resp_rdata=0xDEADBEEF two cycles after accept.
REQ-036 Bench: with word 4 = 0xDEADBEEF, sb 0x55 @0x12 -> RD then WR of 0xDE55BEEF; then lb @0x12 -> 0x00000055; lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE.
REQ-037 Bench: lh @0x11, lw @0x12, size=11, lw @0x1000 (MEM_WORDS=1024) -> resp_err=1 one cycle after accept, no memory strobes.
REQ-038 Bench: a new req_valid held during RD/WR/RESP -> req_ready=0 and the new request is not accepted until IDLE.
REQ-039 Bench: rst_n dropped mid-WR of a sub-word store -> mem_write falls without waiting for a clock, no resp_valid, and the next request after reset completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM state
// encoding and the alignment legality helper.
package load_store_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRd   = 2'b01,
        StWr   = 2'b10,
        StResp = 2'b11
    } lsu_state_e;

    // True when the size code is illegal or the low address bits break natural alignment.
    function automatic logic access_illegal(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling shared by loads and sub-word stores: extracts and
// extends the addressed byte/halfword of a memory word, and merges store data
// into the addressed lane of that same word.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane and extend it to a full word.
    always_comb begin
        byte_sel = 8'h00;
        unique case (lane_i)
            2'd0: byte_sel = word_i[7:0];
            2'd1: byte_sel = word_i[15:8];
            2'd2: byte_sel = word_i[23:16];
            2'd3: byte_sel = word_i[31:24];
        endcase
        half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
        case (size_i)
            SZ_BYTE: load_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            default: load_o = word_i;
        endcase
    end

    // Replace only the addressed lane, keeping every other bit of the word.
    always_comb begin
        merge_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                unique case (lane_i)
                    2'd0: merge_o[7:0]   = wdata_i[7:0];
                    2'd1: merge_o[15:8]  = wdata_i[7:0];
                    2'd2: merge_o[23:16] = wdata_i[7:0];
                    2'd3: merge_o[31:24] = wdata_i[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane_i[1]) merge_o[31:16] = wdata_i[15:0];
                else           merge_o[15:0]  = wdata_i[15:0];
            end
            default: merge_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between a CPU request port and a
// word-wide data memory. Sub-word stores are done as read-modify-write.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata
);

    // 33 bits so the limit cannot wrap for the largest legal depth.
    localparam logic [32:0] AddrLimit = 33'(MEM_WORDS) << 2;

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, wdata_q, rword_q;
    logic [1:0]  size_q;
    logic        uns_q, write_q, err_q;
    logic        req_err, accept;
    logic [31:0] load_word, merge_word;

    assign accept  = req_valid && (state_q == StIdle);
    assign req_err = access_illegal(req_size, req_addr[1:0]) || ({1'b0, req_addr} >= AddrLimit);

    // State register, request capture at accept, memory word capture at the end of RD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            rword_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                write_q <= req_write;
                err_q   <= req_err;
            end
            if (state_q == StRd) begin
                rword_q <= mem_rdata;
            end
        end
    end

    lsu_lane_align u_lane_align (
        .word_i     (rword_q),
        .lane_i     (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .load_o     (load_word),
        .merge_o    (merge_word)
    );

    assign mem_addr  = {2'b00, addr_q[31:2]};
    assign mem_wdata = (size_q == SZ_WORD) ? wdata_q : merge_word;

    // Next-state and strobe/response decode; strobes come straight from state so
    // an asynchronous reset removes them at once.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)                    state_d = StResp;
                    else if (!req_write)            state_d = StRd;
                    else if (req_size == SZ_WORD)   state_d = StWr;
                    else                            state_d = StRd;
                end
            end
            StRd: begin
                mem_read = 1'b1;
                state_d  = write_q ? StWr : StResp;
            end
            StWr: begin
                mem_write = 1'b1;
                state_d   = StResp;
            end
            StResp: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (!err_q && !write_q) ? load_word : '0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
